clock_reset_sequencer: RTL and testbench

CLOCK_RESET_SEQUENCER -- requirements
Module: clock_reset_sequencer

---
 rtl/clock_reset_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_clock_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_reset_sequencer.sv
// Power-up sequencer: holds the board in reset, kicks the clock-cleaner load,
// waits for cleaner and MMCM lock, then releases the domain resets one by one.
module clock_reset_sequencer #(
    parameter int NUM_DOMAINS     = 2,
    parameter int POR_CYCLES      = 125000000,
    parameter int SYNC_STAGES     = 3,
    parameter int LOCK_FILTER     = 16,
    parameter int MMCM_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 1250000,
    parameter int MAX_RETRIES     = 3,
    parameter int RELEASE_GAP     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cc_locked,
    input  logic                   mmcm_locked,
    input  logic                   soc_ready,
    input  logic                   cfg_done,
    output logic                   cfg_start,
    output logic                   mmcm_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic [2:0]             state,
    output logic [7:0]             retry_count,
    output logic [15:0]            lock_loss_count,
    output logic                   fault
);

    typedef enum logic [2:0] {
        S_POR       = 3'd0,
        S_CONFIG    = 3'd1,
        S_WAIT_CC   = 3'd2,
        S_MMCM_RST  = 3'd3,
        S_WAIT_MMCM = 3'd4,
        S_RELEASE   = 3'd5,
        S_RUN       = 3'd6,
        S_FAULT     = 3'd7
    } state_e;

    localparam int FW       = $clog2(LOCK_FILTER + 1);
    localparam int LAST_REL = (NUM_DOMAINS - 1) * RELEASE_GAP;

    logic [SYNC_STAGES-1:0] cc_sync_q, mm_sync_q, soc_sync_q;
    logic                   cc_s, mm_s, soc_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_sync_q  <= '0;
            mm_sync_q  <= '0;
            soc_sync_q <= '0;
        end else begin
            cc_sync_q  <= {cc_sync_q[SYNC_STAGES-2:0], cc_locked};
            mm_sync_q  <= {mm_sync_q[SYNC_STAGES-2:0], mmcm_locked};
            soc_sync_q <= {soc_sync_q[SYNC_STAGES-2:0], soc_ready};
        end
    end

    assign cc_s  = cc_sync_q[SYNC_STAGES-1];
    assign mm_s  = mm_sync_q[SYNC_STAGES-1];
    assign soc_s = soc_sync_q[SYNC_STAGES-1];

    // Lock qualifiers: index 0 = cleaner, 1 = MMCM. Any low sample drops ok at once.
    logic [1:0]         flt_in;
    logic [1:0][FW-1:0] flt_cnt_q;
    logic [1:0]         flt_ok_q;
    logic               cc_ok, mm_ok;

    assign flt_in = {mm_s, cc_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt_q <= '0;
            flt_ok_q  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!flt_in[k]) begin
                    flt_cnt_q[k] <= '0;
                    flt_ok_q[k]  <= 1'b0;
                end else if (flt_cnt_q[k] == FW'(LOCK_FILTER - 1)) begin
                    flt_ok_q[k]  <= 1'b1;
                end else begin
                    flt_cnt_q[k] <= flt_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign cc_ok = flt_ok_q[0];
    assign mm_ok = flt_ok_q[1];

    state_e                 state_q, state_d;
    logic [31:0]            timer_q, timer_d;
    logic [7:0]             retry_q, retry_d;
    logic [15:0]            loss_q, loss_d;
    logic                   cfg_start_q, cfg_start_d;
    logic                   mmcm_rst_q, mmcm_rst_d;
    logic                   fault_q, fault_d;
    logic [NUM_DOMAINS-1:0] drst_q, drst_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            S_POR:      if (timer_q == 32'(POR_CYCLES - 1)) state_d = S_CONFIG;
            S_CONFIG:   if (cfg_done) state_d = S_WAIT_CC;
            S_WAIT_CC:  if (cc_ok) state_d = S_MMCM_RST;
            S_MMCM_RST: if (timer_q == 32'(MMCM_RST_CYCLES - 1)) state_d = S_WAIT_MMCM;
            S_WAIT_MMCM: begin
                if (mm_ok && soc_s) begin
                    state_d = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
                end else if (mm_ok) begin
                    timer_d = timer_q;  // locked but SoC not ready: timeout paused
                end else if (timer_q == 32'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + 8'd1;
                    state_d = (retry_d == 8'(MAX_RETRIES)) ? S_FAULT : S_MMCM_RST;
                end
            end
            S_RELEASE, S_RUN: begin
                if (!cc_ok) begin
                    state_d = S_WAIT_CC;
                    loss_d  = (loss_q == 16'hFFFF) ? loss_q : loss_q + 16'd1;
                end else if (!mm_ok) begin
                    state_d = S_MMCM_RST;
                    loss_d  = (loss_q == 16'hFFFF) ? loss_q : loss_q + 16'd1;
                end else if (!soc_s) begin
                    state_d = S_WAIT_MMCM;
                end else if (state_q == S_RELEASE && timer_q + 32'd1 == 32'(LAST_REL)) begin
                    state_d = S_RUN;
                end
            end
            S_FAULT:    timer_d = timer_q;
            default:    state_d = S_POR;
        endcase

        if (state_d != state_q) timer_d = 32'd0;
        if (state_d == S_RUN && state_q != S_RUN) retry_d = 8'd0;

        // Outputs are computed from the next state so they line up with it.
        cfg_start_d = (state_q == S_POR) && (state_d == S_CONFIG);
        mmcm_rst_d  = (state_d == S_POR) || (state_d == S_CONFIG) || (state_d == S_WAIT_CC) ||
                      (state_d == S_MMCM_RST) || (state_d == S_FAULT);
        fault_d     = (state_d == S_FAULT);
        drst_d      = '1;
        if (state_d == S_RUN) begin
            drst_d = '0;
        end else if (state_d == S_RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++) drst_d[i] = (timer_d < 32'(i * RELEASE_GAP));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_POR;
            timer_q     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            cfg_start_q <= 1'b0;
            mmcm_rst_q  <= 1'b1;
            fault_q     <= 1'b0;
            drst_q      <= '1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            cfg_start_q <= cfg_start_d;
            mmcm_rst_q  <= mmcm_rst_d;
            fault_q     <= fault_d;
            drst_q      <= drst_d;
        end
    end

    assign state           = state_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign cfg_start       = cfg_start_q;
    assign mmcm_rst        = mmcm_rst_q;
    assign fault           = fault_q;
    assign domain_rst      = drst_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Self-checking bench for clock_reset_sequencer with small timing parameters.
module tb_clock_reset_sequencer;

    localparam int ND = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cc_locked = 1'b0, mmcm_locked = 1'b0, soc_ready = 1'b0, cfg_done = 1'b0;
    logic          cfg_start, mmcm_rst, fault;
    logic [ND-1:0] domain_rst;
    logic [2:0]    state;
    logic [7:0]    retry_count;
    logic [15:0]   lock_loss_count;

    int total = 0, passed = 0, starts = 0;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        cc, mm, soc;
        int          hold;
        logic [2:0]  st;
        logic [1:0]  drst;
        logic        mrst;
        logic [15:0] loss;
    } vec_t;

    clock_reset_sequencer #(
        .NUM_DOMAINS(ND), .POR_CYCLES(10), .SYNC_STAGES(3), .LOCK_FILTER(4),
        .MMCM_RST_CYCLES(4), .LOCK_TIMEOUT(20), .MAX_RETRIES(3), .RELEASE_GAP(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cc_locked(cc_locked), .mmcm_locked(mmcm_locked),
        .soc_ready(soc_ready), .cfg_done(cfg_done), .cfg_start(cfg_start),
        .mmcm_rst(mmcm_rst), .domain_rst(domain_rst), .state(state),
        .retry_count(retry_count), .lock_loss_count(lock_loss_count), .fault(fault)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rst_n && cfg_start) starts++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic sb_push(input string nm, input logic [31:0] exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk(e.nm, act, e.exp);
        end
    endtask

    task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(state), 32'(s));
    endtask

    // From reset release: measure POR, check the start pulse, answer with cfg_done.
    task automatic start_seq(input string nm);
        int n = 0;
        while (cfg_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_por_len"}, 32'(n), 32'd10);
        chk({nm, "_config"}, 32'(state), 32'd1);
        tick();
        chk({nm, "_start_pulse"}, 32'(cfg_start), 32'd0);
        tick();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        chk({nm, "_wait_cc"}, 32'(state), 32'd2);
    endtask

    initial begin
        vec_t vt[5];
        int   n;
        int   base;

        vt[0] = '{1'b0, 1'b0, 1'b1, 0,  3'd2, 2'b11, 1'b1, 16'd1};
        vt[1] = '{1'b1, 1'b0, 1'b1, 0,  3'd3, 2'b11, 1'b1, 16'd2};
        vt[2] = '{1'b1, 1'b1, 1'b0, 30, 3'd4, 2'b11, 1'b0, 16'd2};
        vt[3] = '{1'b0, 1'b1, 1'b1, 0,  3'd2, 2'b11, 1'b1, 16'd3};
        vt[4] = '{1'b1, 1'b0, 1'b1, 0,  3'd3, 2'b11, 1'b1, 16'd4};

        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_drst", 32'(domain_rst), 32'd3);
        chk("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        chk("rst_cfg_start", 32'(cfg_start), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retry", 32'(retry_count), 32'd0);
        chk("rst_loss", 32'(lock_loss_count), 32'd0);

        // Nominal bring-up
        cc_locked = 1'b1; mmcm_locked = 1'b1; soc_ready = 1'b1;
        repeat (3) tick();
        base  = starts;
        rst_n = 1'b1;
        start_seq("nom");
        tick();
        chk("nom_mmcm_rst_state", 32'(state), 32'd3);
        chk("nom_mmcm_rst_out", 32'(mmcm_rst), 32'd1);
        n = 0;
        while (state === 3'd3 && n < 20) begin tick(); n++; end
        chk("nom_mmcm_rst_len", 32'(n), 32'd4);
        chk("nom_wait_mmcm", 32'(state), 32'd4);
        chk("nom_mmcm_rst_low", 32'(mmcm_rst), 32'd0);
        tick();
        chk("nom_release", 32'(state), 32'd5);
        chk("nom_drst_10", 32'(domain_rst), 32'd2);
        n = 0;
        while (domain_rst !== 2'b00 && n < 30) begin tick(); n++; end
        chk("nom_release_gap", 32'(n), 32'd8);
        chk("nom_run", 32'(state), 32'd6);
        chk("nom_retry", 32'(retry_count), 32'd0);
        chk("nom_start_count", 32'(starts - base), 32'd1);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        tick();
        chk("cfg_done_ignored", 32'(state), 32'd6);

        // Loss events from RUN
        for (int v = 0; v < 5; v++) begin
            cc_locked = vt[v].cc; mmcm_locked = vt[v].mm; soc_ready = vt[v].soc;
            sb_push($sformatf("v%0d_state", v), 32'(vt[v].st));
            sb_push($sformatf("v%0d_drst", v), 32'(vt[v].drst));
            sb_push($sformatf("v%0d_mmcm_rst", v), 32'(vt[v].mrst));
            sb_push($sformatf("v%0d_loss", v), 32'(vt[v].loss));
            sb_push($sformatf("v%0d_retry", v), 32'd0);
            n = 0;
            while (state === 3'd6 && n < 20) begin tick(); n++; end
            repeat (vt[v].hold) tick();
            sb_pop(32'(state));
            sb_pop(32'(domain_rst));
            sb_pop(32'(mmcm_rst));
            sb_pop(32'(lock_loss_count));
            sb_pop(32'(retry_count));
            cc_locked = 1'b1; mmcm_locked = 1'b1; soc_ready = 1'b1;
            wait_state($sformatf("v%0d_rerelease", v), 3'd5, 100);
            wait_state($sformatf("v%0d_rerun", v), 3'd6, 50);
        end

        // Asynchronous reset in the middle of RELEASE
        soc_ready = 1'b0;
        wait_state("mid_wait_mmcm", 3'd4, 20);
        soc_ready = 1'b1;
        wait_state("mid_release", 3'd5, 20);
        tick();
        tick();
        chk("mid_drst_10", 32'(domain_rst), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_drst", 32'(domain_rst), 32'd3);
        chk("mid_rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        chk("mid_rst_loss", 32'(lock_loss_count), 32'd0);
        cc_locked = 1'b0;
        tick();
        rst_n = 1'b1;

        // Lock glitch: 3 high, 1 low, then a fresh qualifying run
        start_seq("glitch");
        cc_locked = 1'b1;
        repeat (3) tick();
        cc_locked = 1'b0;
        tick();
        cc_locked = 1'b1;
        chk("glitch_hold", 32'(state), 32'd2);
        n = 0;
        while (state !== 3'd3 && n < 30) begin tick(); n++; end
        chk("glitch_filter_len", 32'(n), 32'd8);

        // MMCM never locks: three timeouts then FAULT
        rst_n = 1'b0;
        mmcm_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        start_seq("tmo");
        for (int r = 1; r <= 3; r++) begin
            sb_push($sformatf("tmo%0d_retry", r), 32'(r));
            sb_push($sformatf("tmo%0d_state", r), (r == 3) ? 32'd7 : 32'd3);
        end
        for (int r = 1; r <= 3; r++) begin
            wait_state($sformatf("tmo%0d_wait_mmcm", r), 3'd4, 20);
            n = 0;
            while (state === 3'd4 && n < 40) begin tick(); n++; end
            chk($sformatf("tmo%0d_len", r), 32'(n), 32'd20);
            sb_pop(32'(retry_count));
            sb_pop(32'(state));
        end
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_mmcm_rst", 32'(mmcm_rst), 32'd1);
        chk("fault_drst", 32'(domain_rst), 32'd3);
        mmcm_locked = 1'b1;
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        repeat (40) tick();
        chk("fault_sticky_state", 32'(state), 32'd7);
        chk("fault_sticky_flag", 32'(fault), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("fault_clr_state", 32'(state), 32'd0);
        chk("fault_clr_flag", 32'(fault), 32'd0);
        chk("fault_clr_retry", 32'(retry_count), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
